// File: rtl/led_seq_pkg.sv
// Shared types for the LED mode sequencer: display mode encoding and mode ordering.
package led_seq_pkg;

  localparam int STEP_W = 4;

  typedef enum logic [1:0] {
    GATES   = 2'd0,
    CHASE   = 2'd1,
    BINARY  = 2'd2,
    BREATHE = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      GATES:   return CHASE;
      CHASE:   return BINARY;
      BINARY:  return BREATHE;
      default: return GATES;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer; rise pulses combinationally
// in the cycle whose closing edge flips the debounced level from 0 to 1.
module btn_debounce #(
  parameter int DEB_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic deb,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          btn_s_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ;
  logic          done;

  always_comb begin
    differ = (btn_s_q != deb_q);
    done   = differ && (cnt_q == CNT_MAX);
    deb_d  = deb_q;
    cnt_d  = '0;
    // Any cycle where the synchronised level matches deb restarts the count.
    if (differ) begin
      if (done) deb_d = btn_s_q;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      btn_s_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb  = deb_q;
  assign rise = done & btn_s_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Step-rate LED demo: prescaled 4-bit step, free-running PWM, button-cycled
// display mode and a registered five-LED output.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int STEP_HZ    = 2,
  parameter int DEB_CYCLES = 120_000,
  parameter int PWM_BITS   = 4
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic MODE_BTN,
  output logic RLED1,
  output logic RLED2,
  output logic RLED3,
  output logic RLED4,
  output logic GLED5
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  mode_t               mode_q, mode_d;
  logic [4:0]          led_q, led_d;

  logic                deb_lvl, deb_rise, mode_adv, tick;
  logic                a, b, breathe_on;
  logic [2:0]          tri_lvl;
  logic [PWM_BITS-1:0] duty;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (CLK_IN),
    .rst    (RST_IN),
    .btn_in (MODE_BTN),
    .deb    (deb_lvl),
    .rise   (deb_rise)
  );

  always_comb begin
    mode_adv = deb_rise & ~deb_lvl;
    tick     = (pre_q == PRE_MAX);
    pwm_d    = pwm_q + 1'b1;
    mode_d   = mode_q;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    step_d   = tick ? step_q + 1'b1 : step_q;
    // A mode change restarts the step phase, overriding a same-cycle tick.
    if (mode_adv) begin
      mode_d = next_mode(mode_q);
      pre_d  = '0;
      step_d = '0;
    end
  end

  always_comb begin
    a          = step_q[1];
    b          = step_q[0];
    tri_lvl    = step_q[3] ? ~step_q[2:0] : step_q[2:0];
    duty       = PWM_BITS'(tri_lvl) << (PWM_BITS - 3);
    breathe_on = (pwm_q < duty);
    led_d      = '0;
    case (mode_q)
      GATES:   led_d = {a, b, a & b, a | b, a ^ b};
      CHASE:   led_d = {step_q[1:0] == 2'd0, step_q[1:0] == 2'd1,
                        step_q[1:0] == 2'd2, step_q[1:0] == 2'd3, step_q[2]};
      BINARY:  led_d = {step_q, step_q == 4'hF};
      BREATHE: led_d = {{4{breathe_on}}, ~breathe_on};
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      pre_q  <= '0;
      step_q <= '0;
      pwm_q  <= '0;
      mode_q <= GATES;
      led_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      step_q <= step_d;
      pwm_q  <= pwm_d;
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign {RLED1, RLED2, RLED3, RLED4, GLED5} = led_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with small clock/debounce parameters.
module tb_led_mode_sequencer;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic r1, r2, r3, r4, g5;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  wire [4:0] leds = {r1, r2, r3, r4, g5};

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  led_mode_sequencer #(
    .CLK_HZ     (16),
    .STEP_HZ    (1),
    .DEB_CYCLES (4),
    .PWM_BITS   (4)
  ) dut (
    .CLK_IN   (clk),
    .RST_IN   (rst),
    .MODE_BTN (btn),
    .RLED1    (r1),
    .RLED2    (r2),
    .RLED3    (r3),
    .RLED4    (r4),
    .GLED5    (g5)
  );

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mode_obs();
    return {6'b0, dut.mode_q};
  endfunction

  function automatic logic [4:0] disp_step0(input mode_t m);
    case (m)
      CHASE:   return 5'b10000;
      BREATHE: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Scoreboard
  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic press(input int hold, input mode_t prev, input mode_t nxt);
    int last;
    last = (hold > 7) ? hold : 7;
    exp_q.push_back({6'b0, prev});
    exp_q.push_back({6'b0, nxt});
    exp_q.push_back({3'b0, disp_step0(nxt)});
    btn = 1'b1;
    for (int i = 1; i <= last; i++) begin
      cyc(1);
      if (i == hold) btn = 1'b0;
      if (i == 5) chk("mode_before_adv", mode_obs());
      if (i == 6) chk("mode_after_adv", mode_obs());
      if (i == 7) chk("leds_new_mode", {3'b0, leds});
    end
    cyc(8);
  endtask

  task automatic breathe_window(input string tag, input int on_cnt);
    int r_cnt, g_cnt, bad;
    r_cnt = 0;
    g_cnt = 0;
    bad   = 0;
    exp_q.push_back(8'(on_cnt));
    exp_q.push_back(8'(16 - on_cnt));
    exp_q.push_back(8'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      r_cnt += int'(r1);
      g_cnt += int'(g5);
      if (!(r1 == r2 && r2 == r3 && r3 == r4 && g5 == !r1)) bad++;
    end
    chk({tag, "_red_on"}, 8'(r_cnt));
    chk({tag, "_green_on"}, 8'(g_cnt));
    chk({tag, "_pattern"}, 8'(bad));
  endtask

  task automatic reset_release(input logic btn_level);
    rst = 1'b1;
    btn = btn_level;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(3);
    exp_q.push_back(8'h00);
    chk("reset_leds", {3'b0, leds});
    exp_q.push_back({6'b0, GATES});
    chk("reset_mode", mode_obs());
    rst = 1'b0;

    // GATES over steps 0..3; first tick lands 16 edges after release
    exp_q.push_back(8'b00000); cyc(16); chk("gates_step0", {3'b0, leds});
    exp_q.push_back(8'b01011); cyc(1);  chk("gates_step1", {3'b0, leds});
    exp_q.push_back(8'b10011); cyc(16); chk("gates_step2", {3'b0, leds});
    exp_q.push_back(8'b11110); cyc(16); chk("gates_step3", {3'b0, leds});

    // Reset asserted mid-run clears the LEDs without waiting for a clock
    rst = 1'b1;
    exp_q.push_back(8'h00);
    #1;
    chk("async_reset", {3'b0, leds});
    cyc(2);
    rst = 1'b0;

    // Clean presses walk through all four modes
    press(10, GATES, CHASE);
    press(10, CHASE, BINARY);
    press(10, BINARY, BREATHE);
    press(10, BREATHE, GATES);

    // Bounce: 3 high / 1 low runs never complete the count
    for (int k = 0; k < 5; k++) begin
      btn = 1'b1;
      cyc(3);
      btn = 1'b0;
      cyc(1);
    end
    exp_q.push_back({6'b0, GATES});
    cyc(3);
    chk("bounce_no_change", mode_obs());
    press(6, GATES, CHASE);
    exp_q.push_back({6'b0, CHASE});
    cyc(20);
    chk("single_advance", mode_obs());

    // Press whose debounce completes on the prescaler=15 cycle
    reset_release(1'b0);
    cyc(10);
    press(10, GATES, CHASE);
    exp_q.push_back(8'b10000); cyc(4); chk("coincide_still_step0", {3'b0, leds});
    exp_q.push_back(8'b01000); cyc(1); chk("coincide_step1", {3'b0, leds});

    // Button held across reset release counts as a press
    reset_release(1'b1);
    press(10, GATES, CHASE);

    // BREATHE duty: tri 5 -> 10/16, tri 7 -> 14/16, tri 0 -> 0/16
    reset_release(1'b0);
    press(10, GATES, CHASE);
    press(10, CHASE, BINARY);
    press(10, BINARY, BREATHE);
    cyc(68);
    breathe_window("breathe_step5", 10);
    cyc(32);
    breathe_window("breathe_step8", 14);
    cyc(96);
    breathe_window("breathe_step15", 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
